// File: rtl/link_peer_if.sv
// Signal bundle between the link_peer core and its surroundings: the Game Boy serial
// pins plus the host byte handshakes. The slave modport is the peer's view.
interface link_peer_if;
  logic       gb_active;
  logic       gb_int_clock;
  logic       gb_clk_in;
  logic       gb_data_in;
  logic       gb_clk_out;
  logic       gb_data_out;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overflow;
  logic       busy;

  modport slave (
    input  gb_active, gb_int_clock, gb_clk_in, gb_data_in, tx_byte, tx_valid, rx_ready,
    output gb_clk_out, gb_data_out, tx_ready, rx_byte, rx_valid, rx_overflow, busy
  );

  modport master (
    output gb_active, gb_int_clock, gb_clk_in, gb_data_in, tx_byte, tx_valid, rx_ready,
    input  gb_clk_out, gb_data_out, tx_ready, rx_byte, rx_valid, rx_overflow, busy
  );
endinterface

// File: rtl/link_peer.sv
// Link-cable peer for a Game Boy serial port: exchanges one byte per transfer, either
// following the GB's clock (slave) or generating the serial clock itself (master).
module link_peer #(
  parameter int unsigned CLK_DIV = 511,
  parameter int unsigned TIMEOUT = 4095
) (
  input logic        clk,
  input logic        rst_n,
  link_peer_if.slave bus
);

  localparam int unsigned DivW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int unsigned ToW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV);
  localparam logic [ToW-1:0]  ToMax  = ToW'(TIMEOUT);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StSlave    = 3'd1;
  localparam logic [2:0] StMasterLo = 3'd2;
  localparam logic [2:0] StMasterHi = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            clk_prev_q;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d, to_cnt_inc;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            data_out_q, data_out_d;
  logic            tx_ready_q, tx_ready_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_overflow_q, rx_overflow_d;
  logic            gb_fall, gb_rise;

  assign gb_fall    = clk_prev_q & ~bus.gb_clk_in;
  assign gb_rise    = ~clk_prev_q & bus.gb_clk_in;
  assign to_cnt_inc = (to_cnt_q == ToMax) ? to_cnt_q : to_cnt_q + ToW'(1);

  always_comb begin
    state_d       = state_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    to_cnt_d      = to_cnt_q;
    div_cnt_d     = div_cnt_q;
    data_out_d    = data_out_q;
    tx_ready_d    = 1'b0;
    rx_byte_d     = rx_byte_q;
    rx_valid_d    = rx_valid_q;
    rx_overflow_d = rx_overflow_q;

    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.gb_active && bus.gb_int_clock) begin
          // Nothing queued: answer with 0xFF, as an unplugged cable would.
          state_d    = StSlave;
          tx_shift_d = bus.tx_valid ? bus.tx_byte : 8'hFF;
          tx_ready_d = bus.tx_valid;
          data_out_d = 1'b1;
          bit_cnt_d  = 4'd0;
          to_cnt_d   = '0;
        end else if (bus.gb_active && bus.tx_valid) begin
          state_d    = StMasterLo;
          tx_shift_d = bus.tx_byte;
          tx_ready_d = 1'b1;
          data_out_d = bus.tx_byte[7];
          bit_cnt_d  = 4'd0;
          div_cnt_d  = '0;
        end
      end
      StSlave: begin
        if (gb_rise) begin
          rx_shift_d = {rx_shift_q[6:0], bus.gb_data_in};
          tx_shift_d = {tx_shift_q[6:0], 1'b1};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          to_cnt_d   = '0;
          if (bit_cnt_q == 4'd7) state_d = StDone;
        end else if (gb_fall) begin
          data_out_d = tx_shift_q[7];
          to_cnt_d   = '0;
        end else begin
          to_cnt_d = to_cnt_inc;
          if (to_cnt_inc == ToMax) state_d = StIdle;
        end
      end
      StMasterLo: begin
        if (!bus.gb_active) begin
          state_d = StIdle;
        end else if (div_cnt_q == DivMax) begin
          state_d    = StMasterHi;
          div_cnt_d  = '0;
          rx_shift_d = {rx_shift_q[6:0], bus.gb_data_in};
          tx_shift_d = {tx_shift_q[6:0], 1'b1};
          bit_cnt_d  = bit_cnt_q + 4'd1;
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
      StMasterHi: begin
        if (!bus.gb_active) begin
          state_d = StIdle;
        end else if (div_cnt_q == DivMax) begin
          div_cnt_d = '0;
          if (bit_cnt_q == 4'd8) begin
            state_d = StDone;
          end else begin
            state_d    = StMasterLo;
            data_out_d = tx_shift_q[7];
          end
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
      StDone: begin
        state_d    = StIdle;
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        if (rx_valid_q && !bus.rx_ready) rx_overflow_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      clk_prev_q    <= 1'b1;
      tx_shift_q    <= 8'h00;
      rx_shift_q    <= 8'h00;
      bit_cnt_q     <= 4'd0;
      to_cnt_q      <= '0;
      div_cnt_q     <= '0;
      data_out_q    <= 1'b1;
      tx_ready_q    <= 1'b0;
      rx_byte_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_prev_q    <= bus.gb_clk_in;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
      div_cnt_q     <= div_cnt_d;
      data_out_q    <= data_out_d;
      tx_ready_q    <= tx_ready_d;
      rx_byte_q     <= rx_byte_d;
      rx_valid_q    <= rx_valid_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end

  assign bus.gb_clk_out  = (state_q != StMasterLo);
  assign bus.gb_data_out = (state_q == StIdle) ? 1'b1 : data_out_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_byte     = rx_byte_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overflow = rx_overflow_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_link_peer.sv
// Directed bench for link_peer: slave and master exchanges, overflow, timeout,
// abort and mid-transfer reset, with hand-computed expectations.
module tb_link_peer;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  link_peer_if bus ();

  link_peer #(
    .CLK_DIV (3),
    .TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Acts as the GB driving the serial clock: data changes on the fall, peer samples on rise.
  // Returns at the negedge right after the cycle that sees the last rise.
  task automatic gb_bits(input logic [7:0] out, input int n, output logic [7:0] seen);
    seen = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.gb_clk_in  = 1'b0;
      bus.gb_data_in = out[7-i];
      step(3);
      seen = {seen[6:0], bus.gb_data_out};
      bus.gb_clk_in = 1'b1;
      step(1);
      if (i != n - 1) step(2);
    end
  endtask

  task automatic slave_byte(input logic [7:0] gb_byte, input logic ready_on_done);
    logic [7:0] seen;
    bus.gb_int_clock = 1'b1;
    bus.gb_active    = 1'b1;
    bus.tx_valid     = 1'b0;
    step(1);
    gb_bits(gb_byte, 8, seen);
    bus.gb_active = 1'b0;
    bus.rx_ready  = ready_on_done;
    step(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic drain_rx();
    bus.rx_ready = 1'b1;
    step(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_tests++;
    if (bus.gb_clk_out !== 1'b1 || bus.gb_data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pins: got clk=%b data=%b want 1 1", bus.gb_clk_out, bus.gb_data_out);
    end
    n_tests++;
    if (bus.rx_byte !== 8'h00 || bus.rx_valid !== 1'b0 || bus.rx_overflow !== 1'b0 ||
        bus.tx_ready !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got rx=%h v=%b ov=%b rdy=%b busy=%b want 00 0 0 0 0",
               bus.rx_byte, bus.rx_valid, bus.rx_overflow, bus.tx_ready, bus.busy);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_slave_exchange();
    logic [7:0] seen;
    bus.gb_int_clock = 1'b1;
    bus.gb_active    = 1'b1;
    bus.tx_byte      = 8'h3C;
    bus.tx_valid     = 1'b1;
    step(1);
    n_tests++;
    if (bus.tx_ready !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL slave_accept: got rdy=%b busy=%b want 1 1", bus.tx_ready, bus.busy);
    end
    bus.tx_valid = 1'b0;
    step(1);
    n_tests++;
    if (bus.tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL slave_ready_once: got %b want 0", bus.tx_ready);
    end
    gb_bits(8'hA5, 8, seen);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL slave_done_state: got busy=%b v=%b want 1 0", bus.busy, bus.rx_valid);
    end
    bus.gb_active = 1'b0;
    step(1);
    n_tests++;
    if (bus.rx_valid !== 1'b1 || bus.rx_byte !== 8'hA5 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL slave_rx: got v=%b rx=%h busy=%b want 1 a5 0",
               bus.rx_valid, bus.rx_byte, bus.busy);
    end
    n_tests++;
    if (seen !== 8'h3C) begin
      n_fail++;
      $display("FAIL slave_tx_bits: got %h want 3c", seen);
    end
    drain_rx();
    n_tests++;
    if (bus.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_clear: got %b want 0", bus.rx_valid);
    end
  endtask

  task automatic test_slave_no_tx();
    logic [7:0] seen;
    bus.gb_int_clock = 1'b1;
    bus.gb_active    = 1'b1;
    bus.tx_byte      = 8'h00;
    bus.tx_valid     = 1'b0;
    step(1);
    n_tests++;
    if (bus.tx_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL notx_accept: got rdy=%b busy=%b want 0 1", bus.tx_ready, bus.busy);
    end
    gb_bits(8'h12, 8, seen);
    bus.gb_active = 1'b0;
    step(1);
    n_tests++;
    if (seen !== 8'hFF || bus.rx_byte !== 8'h12) begin
      n_fail++;
      $display("FAIL notx_bytes: got gb=%h rx=%h want ff 12", seen, bus.rx_byte);
    end
    drain_rx();
  endtask

  task automatic test_master();
    logic [7:0] rxpat;
    logic [7:0] tx_seen;
    logic       exp_clk;
    int         bad_clk;
    rxpat   = 8'h5A;
    tx_seen = 8'h00;
    bad_clk = 0;
    bus.gb_int_clock = 1'b0;
    bus.gb_clk_in    = 1'b1;
    bus.tx_byte      = 8'h81;
    bus.tx_valid     = 1'b1;
    bus.gb_data_in   = rxpat[7];
    bus.gb_active    = 1'b1;
    step(1);
    n_tests++;
    if (bus.tx_ready !== 1'b1 || bus.gb_data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL master_start: got rdy=%b data=%b want 1 1", bus.tx_ready, bus.gb_data_out);
    end
    bus.tx_valid = 1'b0;
    for (int c = 0; c < 64; c++) begin
      exp_clk = ((c / 4) % 2) == 1;
      if (bus.gb_clk_out !== exp_clk) bad_clk++;
      if (c % 8 == 0) bus.gb_data_in = rxpat[7 - c / 8];
      if (c % 8 == 3) tx_seen = {tx_seen[6:0], bus.gb_data_out};
      if (c < 63) step(1);
    end
    n_tests++;
    if (bad_clk != 0) begin
      n_fail++;
      $display("FAIL master_clk_wave: got %0d bad cycles want 0", bad_clk);
    end
    n_tests++;
    if (tx_seen !== 8'h81) begin
      n_fail++;
      $display("FAIL master_tx_bits: got %h want 81", tx_seen);
    end
    step(1);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.gb_clk_out !== 1'b1 || bus.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL master_done_64: got busy=%b clk=%b v=%b want 1 1 0",
               bus.busy, bus.gb_clk_out, bus.rx_valid);
    end
    bus.gb_active = 1'b0;
    step(1);
    n_tests++;
    if (bus.rx_valid !== 1'b1 || bus.rx_byte !== 8'h5A || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL master_rx: got v=%b rx=%h busy=%b want 1 5a 0",
               bus.rx_valid, bus.rx_byte, bus.busy);
    end
    drain_rx();
  endtask

  task automatic test_overflow();
    slave_byte(8'h11, 1'b0);
    slave_byte(8'h22, 1'b0);
    n_tests++;
    if (bus.rx_byte !== 8'h22 || bus.rx_overflow !== 1'b1 || bus.rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got rx=%h ov=%b v=%b want 22 1 1",
               bus.rx_byte, bus.rx_overflow, bus.rx_valid);
    end
    drain_rx();
    step(2);
    n_tests++;
    if (bus.rx_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b want 1", bus.rx_overflow);
    end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    slave_byte(8'h33, 1'b0);
    slave_byte(8'h44, 1'b1);
    n_tests++;
    if (bus.rx_byte !== 8'h44 || bus.rx_overflow !== 1'b0 || bus.rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_ready: got rx=%h ov=%b v=%b want 44 0 1",
               bus.rx_byte, bus.rx_overflow, bus.rx_valid);
    end
    drain_rx();
  endtask

  task automatic test_timeout();
    logic [7:0] seen;
    bus.gb_int_clock = 1'b1;
    bus.gb_active    = 1'b1;
    bus.tx_valid     = 1'b0;
    step(1);
    gb_bits(8'hF0, 3, seen);
    bus.gb_active = 1'b0;
    step(14);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: got busy=%b want 1", bus.busy);
    end
    step(1);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.rx_valid !== 1'b0 || bus.gb_data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_idle: got busy=%b v=%b data=%b want 0 0 1",
               bus.busy, bus.rx_valid, bus.gb_data_out);
    end
  endtask

  task automatic test_abort();
    bus.gb_int_clock = 1'b0;
    bus.tx_byte      = 8'h81;
    bus.tx_valid     = 1'b1;
    bus.gb_active    = 1'b1;
    step(1);
    bus.tx_valid = 1'b0;
    step(33);
    n_tests++;
    if (bus.gb_clk_out !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got clk=%b busy=%b want 0 1", bus.gb_clk_out, bus.busy);
    end
    bus.gb_active = 1'b0;
    step(1);
    n_tests++;
    if (bus.gb_clk_out !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got clk=%b busy=%b want 1 0", bus.gb_clk_out, bus.busy);
    end
    step(3);
    n_tests++;
    if (bus.rx_valid !== 1'b0 || bus.rx_byte !== 8'h44) begin
      n_fail++;
      $display("FAIL abort_discard: got v=%b rx=%h want 0 44", bus.rx_valid, bus.rx_byte);
    end
  endtask

  task automatic test_reset_mid();
    bus.gb_int_clock = 1'b0;
    bus.tx_byte      = 8'h00;
    bus.tx_valid     = 1'b1;
    bus.gb_active    = 1'b1;
    step(1);
    bus.tx_valid = 1'b0;
    step(17);
    n_tests++;
    if (bus.gb_clk_out !== 1'b0 || bus.gb_data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pre: got clk=%b data=%b want 0 0", bus.gb_clk_out, bus.gb_data_out);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.gb_clk_out !== 1'b1 || bus.gb_data_out !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pins: got clk=%b data=%b busy=%b want 1 1 0",
               bus.gb_clk_out, bus.gb_data_out, bus.busy);
    end
    n_tests++;
    if (bus.rx_byte !== 8'h00 || bus.rx_valid !== 1'b0 || bus.tx_ready !== 1'b0 ||
        bus.rx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_status: got rx=%h v=%b rdy=%b ov=%b want 00 0 0 0",
               bus.rx_byte, bus.rx_valid, bus.tx_ready, bus.rx_overflow);
    end
    step(1);
    bus.gb_active = 1'b0;
    rst_n = 1'b1;
    step(3);
    n_tests++;
    if (bus.tx_ready !== 1'b0 || bus.rx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: got rdy=%b v=%b busy=%b want 0 0 0",
               bus.tx_ready, bus.rx_valid, bus.busy);
    end
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.gb_active    = 1'b0;
    bus.gb_int_clock = 1'b0;
    bus.gb_clk_in    = 1'b1;
    bus.gb_data_in   = 1'b1;
    bus.tx_byte      = 8'h00;
    bus.tx_valid     = 1'b0;
    bus.rx_ready     = 1'b0;
    test_reset();
    test_slave_exchange();
    test_slave_no_tx();
    test_master();
    test_overflow();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
